vga_timing_gen: RTL and testbench

//   Pixel-timing master for the 640x480@60 display path. Divides mastClk down to a

---
 rtl/vga_timing_pkg.sv | 44 ++++
 rtl/pix_tick_div.sv | 44 ++++
 rtl/vga_timing_gen.sv | 151 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared constants for the 640x480@60 display path: default timing values,
//   raster totals, the visible-window origin used by the sprite controllers
//   for grid offsets, and the types used by the raster generator.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    // mastClk cycles per pixel (100 MHz -> 25 MHz)
    localparam int CLK_DIV    = 4;

    // Horizontal timing, in pixels
    localparam int H_SYNC     = 96;
    localparam int H_BP       = 48;
    localparam int H_ACTIVE   = 640;
    localparam int H_FP       = 16;
    localparam int H_TOTAL    = H_SYNC + H_BP + H_ACTIVE + H_FP;

    // Vertical timing, in lines
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 33;
    localparam int V_ACTIVE   = 480;
    localparam int V_FP       = 10;
    localparam int V_TOTAL    = V_SYNC + V_BP + V_ACTIVE + V_FP;

    // First visible pixel / line (sprite controllers offset their grids by these)
    localparam int HVIS_START = H_SYNC + H_BP;
    localparam int VVIS_START = V_SYNC + V_BP;

    // Raster counters are 10 bits wide; totals above 1024 cannot be represented.
    localparam int CNT_W      = 10;
    localparam int CNT_LIMIT  = 1 << CNT_W;

    typedef logic [CNT_W-1:0] cnt_t;

    // Registered sync/blank levels. h_sync and v_sync carry the pin level
    // (low during the pulse); bright is high inside the visible window.
    typedef struct packed {
        logic h_sync;
        logic v_sync;
        logic bright;
    } sync_t;

endpackage

// File: rtl/pix_tick_div.sv
// ---------------------------------------------------------------------------
// pix_tick_div
//   Divides mastClk down to a one-cycle pixel enable. The divider counts
//   0..CLK_DIV-1 and wraps; pix_en is registered and goes high on the edge
//   where the divider wraps, so the first pix_en after reset release appears
//   on the CLK_DIV-th rising edge.
//
//   Parameters
//     CLK_DIV   mastClk cycles per pixel (>= 2, checked by the parent)
//   Ports
//     mastClk   in   system clock
//     rst_n     in   asynchronous active-low reset
//     tick      out  combinational: pix_en will be high after the next edge;
//                    the raster counters advance on that same edge
//     pix_en    out  registered one-mastClk pulse per pixel period
// ---------------------------------------------------------------------------
module pix_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic mastClk,
    input  logic rst_n,
    output logic tick,
    output logic pix_en
);

    localparam int               DIV_W    = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    assign tick = (div == DIV_LAST);

    always_ff @(posedge mastClk or negedge rst_n) begin
        if (!rst_n) begin
            div    <= '0;
            pix_en <= 1'b0;
        end else begin
            // NOTE: non-blocking so pix_en and div both sample the pre-edge div value.
            pix_en <= tick;
            div    <= tick ? '0 : div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Pixel-timing master for the 640x480@60 display path. Divides mastClk to a
//   pixel-rate enable (pix_tick_div) and runs the horizontal/vertical raster
//   counters. hSync, vSync and bright are decoded from the next count values
//   and registered with the counts, so they always describe the position
//   held in the same cycle. frame_tick pulses for one mastClk cycle when the
//   raster returns to (0,0); it does not fire on reset release.
//
//   Build option
//     SYNC_DELAY_EN  when defined, hSync/vSync/bright pass through one more
//                    register updated once per pixel, lagging the counts by
//                    one pixel to match a one-pixel pipelined rgb path.
//                    frame_tick is not delayed.
//
//   Ports
//     mastClk     in   1   system clock, 100 MHz
//     rst_n       in   1   asynchronous active-low reset
//     pix_en      out  1   one-mastClk pulse per pixel period
//     hCount      out  10  horizontal position, 0..H_TOTAL-1
//     vCount      out  10  vertical position, 0..V_TOTAL-1
//     hSync       out  1   horizontal sync, active low
//     vSync       out  1   vertical sync, active low
//     bright      out  1   high inside the visible window
//     frame_tick  out  1   one-cycle pulse on the (799,524)->(0,0) wrap
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV  = vga_timing_pkg::CLK_DIV,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP
) (
    input  logic       mastClk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frame_tick
);

    import vga_timing_pkg::*;

    localparam int   H_LEN  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int   V_LEN  = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam cnt_t H_LAST = cnt_t'(H_LEN - 1);
    localparam cnt_t V_LAST = cnt_t'(V_LEN - 1);

    // Illegal parameter sets stop elaboration rather than silently aliasing.
    if (H_LEN > CNT_LIMIT) begin : g_h_too_long
        $error("vga_timing_gen: horizontal total %0d exceeds %0d", H_LEN, CNT_LIMIT);
    end
    if (V_LEN > CNT_LIMIT) begin : g_v_too_long
        $error("vga_timing_gen: vertical total %0d exceeds %0d", V_LEN, CNT_LIMIT);
    end
    if (CLK_DIV < 2) begin : g_div_too_small
        $error("vga_timing_gen: CLK_DIV %0d must be at least 2", CLK_DIV);
    end

    // Sync/blank levels for a raster position. Compared as int so a window
    // ending exactly at the 10-bit limit still decodes correctly.
    function automatic sync_t decode(input cnt_t h, input cnt_t v);
        int    hi;
        int    vi;
        sync_t s;
        hi       = int'(h);
        vi       = int'(v);
        s.h_sync = (hi >= H_SYNC);
        s.v_sync = (vi >= V_SYNC);
        s.bright = (hi >= H_SYNC + H_BP) && (hi < H_SYNC + H_BP + H_ACTIVE) &&
                   (vi >= V_SYNC + V_BP) && (vi < V_SYNC + V_BP + V_ACTIVE);
        return s;
    endfunction

    logic  tick;
    logic  frame_wrap;
    cnt_t  h_next;
    cnt_t  v_next;
    sync_t sync_now;
    sync_t sync_out;

    pix_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .mastClk (mastClk),
        .rst_n   (rst_n),
        .tick    (tick),
        .pix_en  (pix_en)
    );

    always_comb begin
        // NOTE: hold values assigned first so no path leaves a variable unassigned (no latch).
        h_next = hCount;
        v_next = vCount;
        if (tick) begin
            if (hCount == H_LAST) begin
                h_next = '0;
                v_next = (vCount == V_LAST) ? '0 : vCount + cnt_t'(1);
            end else begin
                h_next = hCount + cnt_t'(1);
            end
        end
    end

    // The edge that wraps the raster to (0,0) is the one that raises frame_tick,
    // so the pulse lines up with the first (0,0) cycle. Reset alone never sets it.
    assign frame_wrap = tick && (hCount == H_LAST) && (vCount == V_LAST);

    always_ff @(posedge mastClk or negedge rst_n) begin
        if (!rst_n) begin
            hCount     <= '0;
            vCount     <= '0;
            sync_now   <= '0;
            frame_tick <= 1'b0;
        end else begin
            hCount     <= h_next;
            vCount     <= v_next;
            sync_now   <= decode(h_next, v_next);
            frame_tick <= frame_wrap;
        end
    end

`ifdef SYNC_DELAY_EN
    // One-pixel lag: captures the levels of the pixel being left behind.
    sync_t sync_dly;

    always_ff @(posedge mastClk or negedge rst_n) begin
        if (!rst_n) begin
            sync_dly <= '0;
        end else if (tick) begin
            sync_dly <= sync_now;
        end
    end

    assign sync_out = sync_dly;
`else
    assign sync_out = sync_now;
`endif

    assign hSync  = sync_out.h_sync;
    assign vSync  = sync_out.v_sync;
    assign bright = sync_out.bright;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two instances run side by side:
//     dut_a  a shrunken raster (CLK_DIV=3, 22x12) so many whole frames, wraps
//            and randomly placed asynchronous resets fit in the run;
//     dut_b  the default 640x480 timing, covering first pix_en, line-0 sync,
//            the vSync edge at line 2 and the (799,10)->(0,11) wrap.
//   A reference model derives every output from the number of clock edges
//   since reset release (pixel index = edges / CLK_DIV, position = index
//   modulo the frame) and pushes the expectation into a per-instance queue;
//   a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct packed {
        int cd;
        int hs;
        int hbp;
        int ha;
        int hfp;
        int vs;
        int vbp;
        int va;
        int vfp;
    } cfg_t;

    typedef struct packed {
        logic       pix_en;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       br;
        logic       ft;
    } obs_t;

    localparam cfg_t CFG_A = '{cd: 3, hs: 5, hbp: 3, ha: 12, hfp: 2,
                               vs: 2, vbp: 2, va: 6, vfp: 2};
    localparam cfg_t CFG_B = '{cd: 4, hs: 96, hbp: 48, ha: 640, hfp: 16,
                               vs: 2, vbp: 33, va: 480, vfp: 10};

    localparam longint FRAME_A = longint'(CFG_A.cd) *
        longint'(CFG_A.hs + CFG_A.hbp + CFG_A.ha + CFG_A.hfp) *
        longint'(CFG_A.vs + CFG_A.vbp + CFG_A.va + CFG_A.vfp);

    logic mastClk = 1'b0;
    logic rst_n_a = 1'b1;
    logic rst_n_b = 1'b1;

    always #5 mastClk = ~mastClk;

    logic       pix_en_a, hs_a, vs_a, br_a, ft_a;
    logic [9:0] h_a, v_a;
    logic       pix_en_b, hs_b, vs_b, br_b, ft_b;
    logic [9:0] h_b, v_b;
    obs_t       obs_a, obs_b;

    assign obs_a = {pix_en_a, h_a, v_a, hs_a, vs_a, br_a, ft_a};
    assign obs_b = {pix_en_b, h_b, v_b, hs_b, vs_b, br_b, ft_b};

    vga_timing_gen #(
        .CLK_DIV (CFG_A.cd), .H_SYNC (CFG_A.hs), .H_BP (CFG_A.hbp),
        .H_ACTIVE(CFG_A.ha), .H_FP   (CFG_A.hfp), .V_SYNC (CFG_A.vs),
        .V_BP    (CFG_A.vbp), .V_ACTIVE(CFG_A.va), .V_FP  (CFG_A.vfp)
    ) dut_a (
        .mastClk    (mastClk),
        .rst_n      (rst_n_a),
        .pix_en     (pix_en_a),
        .hCount     (h_a),
        .vCount     (v_a),
        .hSync      (hs_a),
        .vSync      (vs_a),
        .bright     (br_a),
        .frame_tick (ft_a)
    );

    vga_timing_gen dut_b (
        .mastClk    (mastClk),
        .rst_n      (rst_n_b),
        .pix_en     (pix_en_b),
        .hCount     (h_b),
        .vCount     (v_b),
        .hSync      (hs_b),
        .vSync      (vs_b),
        .bright     (br_b),
        .frame_tick (ft_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
            if (failures >= 50) begin
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    endtask

    // ---------------- reference model ----------------
    // Levels at raster position (x,y), straight from the timing rules.
    function automatic logic [2:0] levels(input cfg_t c, input longint x, input longint y);
        logic in_h, in_v;
        in_h = (x >= c.hs + c.hbp) && (x < c.hs + c.hbp + c.ha);
        in_v = (y >= c.vs + c.vbp) && (y < c.vs + c.vbp + c.va);
        return {x >= c.hs, y >= c.vs, in_h && in_v};
    endfunction

    // Expected outputs n rising edges after reset release (n=0: reset state).
    function automatic obs_t model(input cfg_t c, input longint n);
        obs_t   o;
        longint line_len, frame_len, p, idx;
        o         = '0;
        line_len  = c.hs + c.hbp + c.ha + c.hfp;
        frame_len = line_len * (c.vs + c.vbp + c.va + c.vfp);
        p         = n / c.cd;              // pixels elapsed
        idx       = p % frame_len;         // position within the frame
        o.pix_en  = (n > 0) && (n % c.cd == 0);
        o.h       = 10'(idx % line_len);
        o.v       = 10'(idx / line_len);
        o.ft      = o.pix_en && (idx == 0);
`ifdef SYNC_DELAY_EN
        if (p > 0) begin
            longint prev;
            prev = (p - 1) % frame_len;
            {o.hs, o.vs, o.br} = levels(c, prev % line_len, prev / line_len);
        end
`else
        {o.hs, o.vs, o.br} = levels(c, idx % line_len, idx / line_len);
`endif
        return o;
    endfunction

    obs_t   q_a[$];
    obs_t   q_b[$];
    longint n_a = 0;
    longint n_b = 0;

    // Stimulus side of the scoreboard: count edges since release, push the
    // expectation late in the cycle (inputs only change 1..3 after posedge).
    initial begin
        forever begin
            @(posedge mastClk);
            if (!rst_n_a) n_a = 0; else n_a++;
            if (!rst_n_b) n_b = 0; else n_b++;
            #4;
            q_a.push_back(rst_n_a ? model(CFG_A, n_a) : obs_t'(0));
            q_b.push_back(rst_n_b ? model(CFG_B, n_b) : obs_t'(0));
        end
    end

    // Monitor: pop and compare on the falling edge.
    longint cyc        = 0;
    longint last_ft_a  = -1;
    int     ft_seen_a  = 0;

    initial begin
        obs_t e;
        forever begin
            @(negedge mastClk);
            cyc++;
            if (q_a.size() == 0) begin
                check("dutA scoreboard underflow", 32'd0, 32'd1);
            end else begin
                e = q_a.pop_front();
                check($sformatf("dutA cyc %0d {pix_en,h,v,hs,vs,br,ft} exp h=%0d v=%0d",
                                cyc, e.h, e.v), 32'(obs_a), 32'(e));
            end
            if (q_b.size() == 0) begin
                check("dutB scoreboard underflow", 32'd0, 32'd1);
            end else begin
                e = q_b.pop_front();
                check($sformatf("dutB cyc %0d {pix_en,h,v,hs,vs,br,ft} exp h=%0d v=%0d",
                                cyc, e.h, e.v), 32'(obs_b), 32'(e));
            end
            // Frame period: consecutive frame_ticks with no reset between them.
            if (!rst_n_a) begin
                last_ft_a = -1;
            end else if (ft_a) begin
                ft_seen_a++;
                if (last_ft_a >= 0)
                    check("dutA frame_tick period", 32'(cyc - last_ft_a), 32'(FRAME_A));
                last_ft_a = cyc;
            end
        end
    end

    // Assert reset between edges; every output must clear before the next edge.
    task automatic pulse_reset(input bit sel_b, input int off, input int hold);
        @(posedge mastClk);
        #(off);
        if (sel_b) rst_n_b = 1'b0; else rst_n_a = 1'b0;
        #1;
        if (sel_b) check("dutB async reset clears outputs", 32'(obs_b), 32'd0);
        else       check("dutA async reset clears outputs", 32'(obs_a), 32'd0);
        repeat (hold) @(posedge mastClk);
        #(1 + $urandom_range(2));
        if (sel_b) rst_n_b = 1'b1; else rst_n_a = 1'b1;
    endtask

    initial begin
        #1;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        #1;
        check("dutA reset state", 32'(obs_a), 32'd0);
        check("dutB reset state", 32'(obs_b), 32'd0);

        fork
            begin : drive_a
                @(posedge mastClk);
                #2 rst_n_a = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    repeat ($urandom_range(3500, 1200)) @(posedge mastClk);
                    pulse_reset(1'b0, int'($urandom_range(3, 1)), int'($urandom_range(4, 1)));
                end
                repeat (2000) @(posedge mastClk);
            end
            begin : drive_b
                @(posedge mastClk);
                #3 rst_n_b = 1'b1;
                repeat (3) @(posedge mastClk);
                #1 check("dutB pix_en low before 4th edge", 32'(pix_en_b), 32'd0);
                @(posedge mastClk);
                #1 check("dutB pix_en on 4th edge", 32'(pix_en_b), 32'd1);
                check("dutB hCount after first pix_en", 32'(h_b), 32'd1);
                // Run past line 11 so the (799,10)->(0,11) wrap is observed.
                repeat (36000) @(posedge mastClk);
                pulse_reset(1'b1, int'($urandom_range(3, 1)), 2);
                repeat (40) @(posedge mastClk);
            end
        join

        repeat (2) @(posedge mastClk);
        check("dutA frame_ticks seen >= 10", 32'(ft_seen_a >= 10), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
